// File: rtl/key_pkg.sv
// Shared types and helpers for the key event decoder: FSM state encoding,
// the idle key word, and the active-low one-hot to key-index encoder.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } key_state_e;

    localparam logic [15:0] KEY_IDLE = 16'hFFFF;

    // Returns {valid, code}; valid only when exactly one bit of the word is low.
    function automatic logic [4:0] onehot_low_to_code(input logic [15:0] key_word);
        logic [15:0] act;
        logic [3:0]  idx;
        logic [4:0]  n_low;
        act   = ~key_word;
        idx   = '0;
        n_low = '0;
        for (int i = 0; i < 16; i++) begin
            if (act[i]) begin
                idx   = 4'(i);
                n_low = n_low + 5'd1;
            end
        end
        return {(n_low == 5'd1), idx};
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small circular event FIFO with registered overflow pulse. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module key_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        overflow_d = push && full && !pop_ok;
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage holds data only; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/key_event_decoder.sv
// Synchronises the scanner key word, debounces press/release, and queues one
// key-code event per accepted press for a valid/ready consumer.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   key,
    input  logic                          pressed,
    input  logic                          code_ready,
    output logic                          code_valid,
    output logic [3:0]                    code,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      key_meta_q, key_meta_d;
    logic [15:0]      key_s_q, key_s_d;
    logic             pressed_meta_q, pressed_meta_d;
    logic             pressed_s_q, pressed_s_d;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;

    logic [4:0]       dec;
    logic             enc_valid;
    logic [3:0]       enc;
    logic             push;
    logic             fifo_empty;

    // Stage boundary: two-flop synchronisers into clk
    always_comb begin
        key_meta_d     = key;
        key_s_d        = key_meta_q;
        pressed_meta_d = pressed;
        pressed_s_d    = pressed_meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta_q     <= KEY_IDLE;
            key_s_q        <= KEY_IDLE;
            pressed_meta_q <= 1'b0;
            pressed_s_q    <= 1'b0;
        end else begin
            key_meta_q     <= key_meta_d;
            key_s_q        <= key_s_d;
            pressed_meta_q <= pressed_meta_d;
            pressed_s_q    <= pressed_s_d;
        end
    end

    assign dec       = onehot_low_to_code(key_s_q);
    assign enc_valid = dec[4];
    assign enc       = dec[3:0];

    // Stage boundary: debounce FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The candidate code is only meaningful outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        cand_q <= cand_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        unique case (state_q)
            IDLE: begin
                if (pressed_s_q && enc_valid) begin
                    cand_d  = enc;
                    cnt_d   = '0;
                    state_d = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!pressed_s_q || !enc_valid || (enc != cand_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                // Rollover to another key while held never produces an event.
                if (!pressed_s_q) begin
                    cnt_d   = '0;
                    state_d = DB_REL;
                end
            end
            DB_REL: begin
                if (pressed_s_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        push = (state_q == DB_PRESS) && pressed_s_q && enc_valid &&
               (enc == cand_q) && (cnt_q == CNT_LAST);
    end

    // Stage boundary: event queue towards the consumer
    key_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (4)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (cand_q),
        .pop       (code_ready),
        .pop_data  (code),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    assign code_valid = !fifo_empty;

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomised and directed bench for key_event_decoder with a run-length
// reference model feeding an event scoreboard checked by a separate monitor.
module tb_key_event_decoder;

    localparam int D     = 8;
    localparam int DEPTH = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [15:0] key        = 16'hFFFF;
    logic        pressed    = 1'b0;
    logic        code_ready = 1'b0;
    logic        code_valid;
    logic [3:0]  code;
    logic        overflow;
    logic [2:0]  fifo_count;

    key_event_decoder #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .pressed    (pressed),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .code       (code),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: written by the model, read by the monitor
    int exp_mem [0:4095];
    int exp_wr = 0;
    int exp_rd = 0;

    // Reference model state (owned by the stimulus process)
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [15:0] k1 = 16'hFFFF, k2 = 16'hFFFF;
    bit          held = 1'b0;
    int          run = 0, rel = 0, run_code = 0;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  final_req  = 1'b0;
    bit  final_done = 1'b0;

    function automatic void decode_key(input logic [15:0] k, output bit ok, output int idx);
        ok  = ($countones(~k) == 1);
        idx = 0;
        for (int i = 0; i < 16; i++) if (!k[i]) idx = i;
    endfunction

    // One clock edge of the specification's behaviour, seen from the synced inputs.
    task automatic model_step();
        bit ok;
        int idx;
        bit ev;
        bit pop;
        if (!reset) begin
            p1 = 1'b0; p2 = 1'b0; k1 = 16'hFFFF; k2 = 16'hFFFF;
            held = 1'b0; run = 0; rel = 0; m_cnt = 0; m_ovf = 1'b0;
            return;
        end
        decode_key(k2, ok, idx);
        ev = 1'b0;
        if (!held) begin
            if (p2 && ok && (run == 0 || idx == run_code)) begin
                if (run == 0) run_code = idx;
                run++;
                if (run == D + 1) begin
                    ev = 1'b1; held = 1'b1; run = 0; rel = 0;
                end
            end else begin
                run = 0;
            end
        end else begin
            if (!p2) begin
                rel++;
                if (rel == D + 1) begin
                    held = 1'b0; rel = 0; run = 0;
                end
            end else begin
                rel = 0;
            end
        end
        pop   = (m_cnt > 0) && code_ready;
        m_ovf = 1'b0;
        if (ev) begin
            if (m_cnt < DEPTH || pop) begin
                exp_mem[exp_wr] = run_code;
                exp_wr++;
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) m_cnt--;
        p2 = p1; k2 = k1;
        p1 = pressed; k1 = key;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int idx, input int hold, input int gap);
        logic [15:0] kw;
        kw = 16'hFFFF;
        kw[idx] = 1'b0;
        key = kw; pressed = 1'b1;
        cycles(hold);
        pressed = 1'b0;
        cycles(gap);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the model and pops the scoreboard
    initial begin
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (!reset) begin
                chk("reset_code_valid", int'(code_valid), 0);
                chk("reset_code", int'(code), 0);
                chk("reset_overflow", int'(overflow), 0);
                chk("reset_fifo_count", int'(fifo_count), 0);
                exp_rd = exp_wr;
            end else begin
                chk("code_valid", int'(code_valid), int'(m_cnt != 0));
                chk("fifo_count", int'(fifo_count), m_cnt);
                chk("overflow", int'(overflow), int'(m_ovf));
                if (code_valid) begin
                    if (exp_rd >= exp_wr) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL head_event: got code %0d, expected no event at %0t", code, $time);
                    end else begin
                        chk("head_code", int'(code), exp_mem[exp_rd]);
                        if (code_ready) exp_rd++;
                    end
                end
            end
            if (final_req && !final_done) begin
                chk("all_events_drained", exp_rd, exp_wr);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        #1 reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(2);

        // Clean press of key 5
        code_ready = 1'b1;
        press(5, 40, 20);

        // Bouncing press of key 0, then a solid one
        key = 16'hFFFE;
        for (int i = 0; i < 10; i++) begin
            pressed = ~pressed;
            cycles(3);
        end
        pressed = 1'b1;
        cycles(20);
        pressed = 1'b0;
        cycles(20);

        // Release glitch while held
        key = 16'hFFF7; pressed = 1'b1;
        cycles(20);
        pressed = 1'b0;
        cycles(4);
        pressed = 1'b1;
        cycles(10);
        pressed = 1'b0;
        cycles(14);

        // Invalid key word with two bits low
        key = 16'hFFFC; pressed = 1'b1;
        cycles(30);
        pressed = 1'b0;
        cycles(10);

        // Overflow: five presses without draining, then drain
        code_ready = 1'b0;
        for (int k = 1; k <= 5; k++) press(k, 14, 14);
        code_ready = 1'b1;
        cycles(10);

        // Reset during DB_PRESS with two events queued
        code_ready = 1'b0;
        press(9, 12, 12);
        press(10, 12, 12);
        key = 16'hFFBF; pressed = 1'b1;
        cycles(5);
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(30);
        code_ready = 1'b1;
        cycles(5);
        pressed = 1'b0;
        cycles(15);

        // Randomised traffic
        for (int it = 0; it < 150; it++) begin
            int r;
            int hold;
            int gap;
            logic [15:0] kw;
            r = int'($urandom_range(0, 9));
            kw = 16'hFFFF;
            if (r < 8) kw[$urandom_range(0, 15)] = 1'b0;
            else if (r == 8) kw = 16'($urandom);
            key = kw;
            code_ready = ($urandom_range(0, 2) != 0);
            hold = int'($urandom_range(1, 20));
            gap  = int'($urandom_range(1, 20));
            pressed = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                cycles(hold / 2 + 1);
                key = ~(16'h1 << $urandom_range(0, 15));
                cycles(hold - hold / 2);
            end else begin
                cycles(hold);
            end
            pressed = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                cycles(2);
                reset = 1'b1;
            end
            cycles(gap);
        end

        code_ready = 1'b1;
        pressed = 1'b0;
        cycles(40);
        final_req = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        if (!final_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL final_check: got not reached, expected reached");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Downstream consumer of the 4x4 keyboard scanner. It takes the scanner's active-low one-hot `key` word and `pressed` flag, both of which change on the slower scan clock. It synchronises them into `clk`, debounces press and release, and encodes the key to a 4-bit code. Each accepted press is queued as a single event in a small FIFO, which is drained through a valid/ready handshake by the application logic (display, calculator, etc.).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive `clk` cycles a press or release must be stable. Legal range is 2 or more.
- `FIFO_DEPTH`, default 4: number of event entries. Must be a power of two, 2 or more.

Ports:
- `clk` input, 1 bit: system clock. Everything in the block runs on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `key` input, 16 bits: scanner key word. It is active-low one-hot, so bit i = 0 means key i. It holds its last value after release.
- `pressed` input, 1 bit: scanner "any key down" flag.
- `code_ready` input, 1 bit: consumer accepts the head event.
- `code_valid` output, 1 bit: the FIFO is non-empty.
- `code` output, 4 bits: key index of the head event, 0..15.
- `overflow` output, 1 bit: one-cycle pulse when an event is dropped because the FIFO is full.
- `fifo_count` output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.

## Operation
**Synchronisation**
- `key` and `pressed` each pass through a 2-flop synchroniser, giving `key_s` and `pressed_s`.
- `key_s` is valid when exactly one bit is 0. `enc` is the index of that bit.

**Debounce FSM**
- States: IDLE, DB_PRESS, HELD, DB_REL.
- The counter `cnt` is $clog2(DEBOUNCE_CYCLES) bits wide.
- IDLE:
  - If `pressed_s`=1 and `key_s` is valid: latch `cand`=`enc`, clear `cnt`, go to DB_PRESS.
  - An invalid `key_s` (zero or two or more bits low) is ignored, and the FSM stays in IDLE.
- DB_PRESS:
  - If `pressed_s`=0, or `key_s` is invalid, or `enc`≠`cand`: go to IDLE with no event.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: push `cand` to the FIFO and go to HELD.
  - Else increment `cnt`.
- HELD:
  - If `pressed_s`=0: clear `cnt` and go to DB_REL.
  - Key changes while held (rollover) are ignored. One event is produced per press.
- DB_REL:
  - If `pressed_s`=1: go to HELD with no new event, because the release was a bounce.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: go to IDLE.
  - Else increment `cnt`.

**FIFO**
- Push comes from the FSM; pop occurs when `code_valid` and `code_ready` are both high.
- Circular read and write pointers wrap modulo FIFO_DEPTH.
- `code` is the entry at the read pointer.
- Push while full with no pop: the event is dropped, `overflow`=1 for one cycle, and the FIFO contents are unchanged.
- Push while full with a pop in the same cycle: both are accepted, and the count stays at FIFO_DEPTH.
- Push while empty: no bypass. `code_valid` rises on the next cycle.
- Pop while empty: impossible, because `code_valid` is 0.

**Reset**
- While `reset`=0 the block returns immediately to its reset state:
  - FSM in IDLE, `cnt`=0.
  - Synchroniser flops: `pressed` path = 0, `key` path = all ones.
  - FIFO pointers and count = 0.
  - Outputs: `code_valid`=0, `code`=0, `overflow`=0, `fifo_count`=0.
- Reset mid-debounce or mid-hold discards the pending press. After reset, a still-held key must go through a full DB_PRESS again.

## Timing
- Synchroniser latency: 2 cycles.
- Press to event latency, measured from the first `clk` edge that samples `pressed`=1 with a stable valid `key`:
  - `pressed_s` is high after edge 2.
  - IDLE moves to DB_PRESS at edge 3.
  - The push happens at edge 3+DEBOUNCE_CYCLES.
  - `code_valid` is high after that same edge.
- The handshake is per cycle: `code` is stable while `code_valid`=1 and `code_ready`=0. A pop takes effect on the clock edge.
- After a pop, the next entry, if present, appears after that edge.
- The minimum interval between two events is 2·DEBOUNCE_CYCLES+2 cycles (press debounce, then release debounce, then IDLE).
- `overflow` is registered and asserts on the same edge as the dropped push.

## Structure
- Package `key_pkg` holds:
  - the FSM state typedef (IDLE, DB_PRESS, HELD, DB_REL);
  - the function `onehot_low_to_code(input [15:0]) -> {valid, [3:0] code}`;
  - the constant `KEY_IDLE = 16'hFFFF`.
- Sub-module `key_fifo` provides the parameterised FIFO with push, pop, full, empty, count and overflow.
- The top level contains the synchronisers, the FSM, the counter and one `key_fifo` instance.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and FIFO_DEPTH=4.
1. Clean press: `key`=16'hFFDF, `pressed`=1 for 40 cycles, then `pressed`=0, `code_ready`=1 → exactly one event, `code`=5. `code_valid` rises 11 cycles after the first sampled edge and is popped on the next cycle.
2. Bounce: toggle `pressed` 1/0 every 3 cycles for 30 cycles with `key`=16'hFFFE → no events. Then hold `pressed` for 20 cycles → one event, `code`=0.
3. Release glitch: during HELD, drop `pressed` for 4 cycles and restore it → no second event. A subsequent release held for 12 cycles returns the FSM to IDLE.
4. Invalid key: `key`=16'hFFFC, `pressed`=1 for 30 cycles → no event, FSM stays in IDLE.
5. Overflow: with `code_ready`=0, make 5 presses of keys 1, 2, 3, 4, 5 → `fifo_count`=4 and one `overflow` pulse on the 5th. Draining then yields 1, 2, 3, 4.
6. Reset: assert `reset`=0 during DB_PRESS with 2 events queued → all outputs are 0 immediately. With the key still held after release of reset, exactly one new event follows a full debounce.
